csr_counter_file: RTL and testbench

Machine-mode CSR storage and performance-counter block. It consumes the writeback stage's CSR write port and retire strobe, and serves a combinational CSR read port to the execute stage. It holds the 64-bit cycle and instret counters, `mcountinhibit` and `mscratch`. CSR writes and counter increments are committed on the same clock edge, with a defined priority between them.

---
 rtl/csr_counter_file_if.sv | 21 ++
 rtl/csr_counter_file.sv | 96 +++++++++
 tb/tb_csr_counter_file.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_counter_file_if.sv
// Writeback CSR write/retire port plus the execute-stage CSR read port,
// bundled for the machine-mode counter file.
interface csr_counter_file_if;
  logic        csr_we_wb_i;
  logic        retire_wb_i;
  logic [11:0] csr_addr_wb_i;
  logic [31:0] csr_result_wb_i;
  logic [11:0] csr_addr_rd_i;
  logic [31:0] csr_data_o;
  logic        csr_illegal_o;

  modport master (
    output csr_we_wb_i, retire_wb_i, csr_addr_wb_i, csr_result_wb_i, csr_addr_rd_i,
    input  csr_data_o, csr_illegal_o
  );

  modport slave (
    input  csr_we_wb_i, retire_wb_i, csr_addr_wb_i, csr_result_wb_i, csr_addr_rd_i,
    output csr_data_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter_file.sv
// Machine-mode CSR storage: 64-bit mcycle/minstret, mcountinhibit, mscratch.
// Writes commit only with retire; the read port is a purely combinational mux.
module csr_counter_file #(
  parameter logic [31:0] MSCRATCH_RESET = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  csr_counter_file_if.slave    csr_bus
);

  logic        wr;
  logic [1:0]  inhibit_q, inhibit_d;   // [0] = CY, [1] = IR
  logic [31:0] mscratch_q, mscratch_d;
  logic [63:0] cnt_val [2];           // [0] = mcycle, [1] = minstret
  logic [31:0] rd_data;
  logic        rd_illegal;

  assign wr = csr_bus.csr_we_wb_i & csr_bus.retire_wb_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [11:0] LO_ADDR = 12'hB00 | 12'(2 * gi);
      localparam logic [11:0] HI_ADDR = 12'hB80 | 12'(2 * gi);
      logic        inc;
      logic [63:0] cnt_q, cnt_d;

      if (gi == 0) begin : g_inc
        assign inc = ~inhibit_q[0];
      end else begin : g_inc
        assign inc = ~inhibit_q[1] & csr_bus.retire_wb_i;
      end

      // A high-half write keeps the low-half increment but drops its carry.
      always_comb begin
        cnt_d = cnt_q;
        if (wr && csr_bus.csr_addr_wb_i == LO_ADDR) begin
          cnt_d = {cnt_q[63:32], csr_bus.csr_result_wb_i};
        end else if (wr && csr_bus.csr_addr_wb_i == HI_ADDR) begin
          cnt_d = {csr_bus.csr_result_wb_i, cnt_q[31:0] + {31'b0, inc}};
        end else if (inc) begin
          cnt_d = cnt_q + 64'd1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          cnt_q <= 64'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_val[gi] = cnt_q;
    end
  endgenerate

  always_comb begin
    inhibit_d  = inhibit_q;
    mscratch_d = mscratch_q;
    if (wr && csr_bus.csr_addr_wb_i == 12'h320) begin
      inhibit_d = {csr_bus.csr_result_wb_i[2], csr_bus.csr_result_wb_i[0]};
    end
    if (wr && csr_bus.csr_addr_wb_i == 12'h340) begin
      mscratch_d = csr_bus.csr_result_wb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inhibit_q  <= 2'b00;
      mscratch_q <= MSCRATCH_RESET;
    end else begin
      inhibit_q  <= inhibit_d;
      mscratch_q <= mscratch_d;
    end
  end

  always_comb begin
    rd_data    = 32'd0;
    rd_illegal = 1'b0;
    case (csr_bus.csr_addr_rd_i)
      12'hB00, 12'hC00: rd_data = cnt_val[0][31:0];
      12'hB80, 12'hC80: rd_data = cnt_val[0][63:32];
      12'hB02, 12'hC02: rd_data = cnt_val[1][31:0];
      12'hB82, 12'hC82: rd_data = cnt_val[1][63:32];
      12'h320:          rd_data = {29'd0, inhibit_q[1], 1'b0, inhibit_q[0]};
      12'h340:          rd_data = mscratch_q;
      default:          rd_illegal = 1'b1;
    endcase
  end

  assign csr_bus.csr_data_o    = rd_data;
  assign csr_bus.csr_illegal_o = rd_illegal;

endmodule

// File: tb/tb_csr_counter_file.sv
// Bench for csr_counter_file: directed vector table, hand-written carry/reset
// sequences, then random traffic checked against a behavioural model.
module tb_csr_counter_file;

  localparam logic [31:0] SCR_RST = 32'h1234_5678;

  logic clk = 1'b0;
  logic reset_i;
  csr_counter_file_if bus ();

  csr_counter_file #(.MSCRATCH_RESET(SCR_RST)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .csr_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        ret;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int passed = 0;

  // Behavioural model: counters as plain 64-bit numbers.
  longint unsigned m_cyc, m_ins;
  bit m_cy, m_ir;
  logic [31:0] m_scr;

  function automatic longint unsigned write_half(longint unsigned v, bit hi,
                                                 logic [31:0] d, bit inc);
    longint unsigned lo;
    if (!hi) return (v & 64'hFFFF_FFFF_0000_0000) | longint'(d);
    lo = ((v & 64'hFFFF_FFFF) + (inc ? 1 : 0)) & 64'hFFFF_FFFF;
    return (longint'(d) << 32) | lo;
  endfunction

  task automatic model_step(bit rst, bit we, bit ret, logic [11:0] wa, logic [31:0] wd);
    bit wr, inc_c, inc_i;
    if (rst) begin
      m_cyc = 0; m_ins = 0; m_cy = 0; m_ir = 0; m_scr = SCR_RST;
      return;
    end
    wr    = we && ret;
    inc_c = !m_cy;
    inc_i = !m_ir && ret;
    if (wr && (wa == 12'hB00 || wa == 12'hB80)) m_cyc = write_half(m_cyc, wa[7], wd, inc_c);
    else if (inc_c) m_cyc = m_cyc + 1;
    if (wr && (wa == 12'hB02 || wa == 12'hB82)) m_ins = write_half(m_ins, wa[7], wd, inc_i);
    else if (inc_i) m_ins = m_ins + 1;
    if (wr && wa == 12'h320) begin m_cy = wd[0]; m_ir = wd[2]; end
    if (wr && wa == 12'h340) m_scr = wd;
  endtask

  function automatic logic [32:0] model_read(logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      12'h320:          return {1'b0, 29'd0, m_ir, 1'b0, m_cy};
      12'h340:          return {1'b0, m_scr};
      default:          return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic cycle(bit rst, bit we, bit ret, logic [11:0] wa, logic [31:0] wd);
    reset_i             = rst;
    bus.csr_we_wb_i     = we;
    bus.retire_wb_i     = ret;
    bus.csr_addr_wb_i   = wa;
    bus.csr_result_wb_i = wd;
    @(posedge clk);
    model_step(rst, we, ret, wa, wd);
    #1;
    $display("[%0t] txn rst=%0b we=%0b ret=%0b waddr=%h wdata=%h", $time, rst, we, ret, wa, wd);
    reset_i         = 1'b0;
    bus.csr_we_wb_i = 1'b0;
    bus.retire_wb_i = 1'b0;
  endtask

  task automatic chk(string name, logic [11:0] a, logic [31:0] exp_d, logic exp_ill);
    bus.csr_addr_rd_i = a;
    #1;
    total++;
    if (bus.csr_data_o !== exp_d || bus.csr_illegal_o !== exp_ill) begin
      $display("FAIL %s addr=%h: got data=%h illegal=%b, expected data=%h illegal=%b",
               name, a, bus.csr_data_o, bus.csr_illegal_o, exp_d, exp_ill);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_model(string name, logic [11:0] a);
    logic [32:0] e;
    e = model_read(a);
    chk(name, a, e[31:0], e[32]);
  endtask

  function automatic vec_t mk(logic we, logic ret, logic [11:0] wa, logic [31:0] wd,
                              logic [11:0] ra, logic [31:0] ed, logic ei);
    vec_t v;
    v.we = we; v.ret = ret; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.exp_data = ed; v.exp_ill = ei;
    return v;
  endfunction

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 12))
      0: return 12'hB00;  1: return 12'hB80;  2: return 12'hB02;  3: return 12'hB82;
      4: return 12'h320;  5: return 12'h340;  6: return 12'hC00;  7: return 12'hC80;
      8: return 12'hC02;  9: return 12'hC82;  10: return 12'h7C0; 11: return 12'h321;
      default: return 12'(($urandom() & 32'hFFF));
    endcase
  endfunction

  initial begin
    logic [11:0] wa;
    logic [31:0] wd;
    bit rst;

    bus.csr_addr_rd_i = 12'hB00;
    m_cyc = 0; m_ins = 0; m_cy = 0; m_ir = 0; m_scr = 32'd0;

    // Directed table, applied from the reset state (mcycle counts every edge).
    for (int k = 1; k <= 10; k++) vecs.push_back(mk(0, 0, 12'h000, 0, 12'hB00, 32'(k), 0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hC00, 32'd11,        0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB02, 32'd0,         0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'h340, SCR_RST,       0));
    vecs.push_back(mk(1, 1, 12'hB00, 32'hFFFF_FFFE, 12'hB00, 32'hFFFF_FFFE, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB00, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB00, 32'd0,         0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB80, 32'd1,         0));
    vecs.push_back(mk(1, 1, 12'hB02, 32'd100,       12'hB02, 32'd100,       0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB02, 32'd101,       0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB02, 32'd102,       0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hC02, 32'd103,       0));
    vecs.push_back(mk(1, 1, 12'h320, 32'd5,         12'h320, 32'd5,         0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB00, 32'd6,         0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB02, 32'd104,       0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB00, 32'd6,         0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB02, 32'd104,       0));
    vecs.push_back(mk(1, 1, 12'h320, 32'd0,         12'hB00, 32'd6,         0));
    vecs.push_back(mk(0, 1, 12'h000, 0,             12'hB02, 32'd105,       0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB00, 32'd8,         0));
    vecs.push_back(mk(1, 0, 12'h340, 32'hDEAD_BEEF, 12'h340, SCR_RST,       0));
    vecs.push_back(mk(1, 1, 12'hC00, 32'd7,         12'hB00, 32'd10,        0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'h7C0, 32'd0,         1));
    vecs.push_back(mk(1, 1, 12'h340, 32'hCAFE_F00D, 12'h340, 32'hCAFE_F00D, 0));
    vecs.push_back(mk(1, 1, 12'hB80, 32'd3,         12'hB80, 32'd3,         0));
    vecs.push_back(mk(0, 0, 12'h000, 0,             12'hB00, 32'd14,        0));

    cycle(1, 0, 0, 12'h000, 0);
    chk("reset_mcycle", 12'hB00, 32'd0, 1'b0);
    chk("reset_minstret", 12'hB02, 32'd0, 1'b0);
    chk("reset_mscratch", 12'h340, SCR_RST, 1'b0);

    foreach (vecs[i]) begin
      cycle(0, vecs[i].we, vecs[i].ret, vecs[i].waddr, vecs[i].wdata);
      chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_data, vecs[i].exp_ill);
    end

    // mcycle high write drops the low-half carry.
    cycle(0, 1, 1, 12'hB00, 32'hFFFF_FFFF);
    cycle(0, 1, 1, 12'hB80, 32'h10);
    chk("cy_hi_write_hi", 12'hB80, 32'h10, 1'b0);
    chk("cy_hi_write_lo", 12'hB00, 32'd0, 1'b0);
    cycle(0, 0, 0, 12'h000, 0);
    chk("cy_after_hi_lo", 12'hB00, 32'd1, 1'b0);
    chk("cy_after_hi_hi", 12'hC80, 32'h10, 1'b0);

    // minstret carry across halves, then a high write with retire increment.
    cycle(0, 1, 1, 12'hB02, 32'hFFFF_FFFF);
    cycle(0, 0, 1, 12'h000, 0);
    chk("ir_carry_hi", 12'hB82, 32'd1, 1'b0);
    chk("ir_carry_lo", 12'hB02, 32'd0, 1'b0);
    cycle(0, 1, 1, 12'hB82, 32'hABCD);
    chk("ir_hi_write_hi", 12'hB82, 32'hABCD, 1'b0);
    chk("ir_hi_write_lo", 12'hB02, 32'd1, 1'b0);

    // Reset wins over a simultaneous retiring write.
    cycle(1, 1, 1, 12'hB80, 32'd3);
    chk("rst_wr_cy_hi", 12'hB80, 32'd0, 1'b0);
    chk("rst_wr_cy_lo", 12'hB00, 32'd0, 1'b0);
    chk("rst_wr_ir_lo", 12'hB02, 32'd0, 1'b0);
    cycle(0, 0, 0, 12'h000, 0);
    chk("rst_first_cnt", 12'hB00, 32'd1, 1'b0);
    chk("rst_inhibit", 12'h320, 32'd0, 1'b0);
    chk("rst_scratch", 12'h340, SCR_RST, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wa  = pick_addr();
      wd  = $urandom();
      if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      if (wa == 12'h320 && $urandom_range(0, 2) != 0) wd = 32'd0;
      rst = ($urandom_range(0, 63) == 0);
      cycle(rst, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, wa, wd);
      chk_model($sformatf("rand%0d", n), pick_addr());
      if (n % 4 == 0) chk_model($sformatf("rand%0d_hi", n), 12'hB80 | 12'(2 * $urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
